// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and bus-side signal bundle for the sprite DMA sequencer.
// The slave modport is the controller's view; the master modport is the
// view of whatever surrounds it (CPU core on one side, memory/PPU decoder
// on the other).
interface oam_dma_ctrl_if;
  // CPU core side
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d;
  logic        cpu_r;
  logic        cpu_w;
  logic        cpu_ce;

  // Memory / PPU decoder side
  logic [15:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_r;
  logic        bus_w;
  logic [7:0]  bus_i;

  // Status
  logic        busy;

  modport slave (
    input  cpu_a, cpu_d, cpu_r, cpu_w, bus_i,
    output cpu_ce, bus_a, bus_d, bus_r, bus_w, busy
  );

  modport master (
    output cpu_a, cpu_d, cpu_r, cpu_w, bus_i,
    input  cpu_ce, bus_a, bus_d, bus_r, bus_w, busy
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer and bus arbiter.
// A CPU write to DMA_REG latches a source page, freezes the CPU by gating its
// cycle tick, and copies 256 bytes from {page,00..FF} to OAM_DATA, one read
// and one write per byte. Outside a transfer the CPU is passed straight
// through to the bus with no added latency.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG     = 16'h4014,
  parameter logic [15:0] OAM_DATA    = 16'h2004,
  parameter logic        PARITY_INIT = 1'b0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  oam_dma_ctrl_if.slave io
);

  // HALT  : first stalled tick, lets the CPU finish its current cycle.
  // ALIGN : extra idle tick so that reads land on the right CPU-cycle phase.
  // READ  : fetch one source byte into the data latch.
  // WRITE : store the latched byte to the OAM data port.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] page;    // source page latched from the triggering write
  logic [7:0] idx;     // byte offset within the page
  logic [7:0] latch;   // byte fetched in READ, presented in WRITE
  logic       parity;  // free-running CPU-cycle phase, toggles every tick

  logic dma_req;

  // A CPU write to the trigger register; only acted on while idle, so a
  // forced write during a transfer (or on its final tick) has no effect.
  assign dma_req = io.cpu_w && (io.cpu_a == DMA_REG);

  // Sequencer state, transfer registers and the cycle-phase bit.
  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values of the others; blocking here would
  // make results depend on statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      page   <= '0;
      idx    <= '0;
      latch  <= '0;
      parity <= PARITY_INIT;
    end else if (ce) begin
      parity <= ~parity;
      case (state)
        IDLE: begin
          if (dma_req) begin
            page  <= io.cpu_d;
            idx   <= '0;
            state <= HALT;
          end
        end
        HALT: begin
          // An odd phase needs one extra tick before the first read.
          state <= parity ? ALIGN : READ;
        end
        ALIGN: begin
          state <= READ;
        end
        READ: begin
          latch <= io.bus_i;
          state <= WRITE;
        end
        WRITE: begin
          if (idx == 8'hFF) begin
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= READ;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Bus and CPU-tick mux: CPU pass-through when idle, DMA addressing otherwise.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    io.bus_a  = OAM_DATA;
    io.bus_d  = latch;
    io.bus_r  = 1'b0;
    io.bus_w  = 1'b0;
    io.cpu_ce = 1'b0;
    case (state)
      IDLE: begin
        io.bus_a  = io.cpu_a;
        io.bus_d  = io.cpu_d;
        io.bus_r  = io.cpu_r;
        io.bus_w  = io.cpu_w;
        io.cpu_ce = ce;
      end
      READ: begin
        io.bus_a = {page, idx};
        io.bus_r = 1'b1;
      end
      WRITE: begin
        io.bus_a = OAM_DATA;
        io.bus_w = 1'b1;
      end
      default: begin
        // HALT / ALIGN: bus parked on the OAM port with both strobes low.
      end
    endcase
  end

  // Transfer-in-progress flag, derived directly from the state register.
  always_comb begin
    io.busy = (state != IDLE);
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl.
// A transfer-level model (tick count since the trigger, byte index = tick/2)
// predicts every output on every cycle; per-transfer read/write logs are
// checked against hand-computed stall counts, addresses and data.
module tb_oam_dma_ctrl;

  localparam logic [15:0] OAM = 16'h2004;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ce    = 1'b0;

  oam_dma_ctrl_if io();

  oam_dma_ctrl dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .io    (io)
  );

  always #5 clock = ~clock;

  // Backing memory seen by the bus; read data is combinational on bus_a.
  logic [7:0] mem [0:65535];
  assign io.bus_i = mem[io.bus_a];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transfer-level model ----------------
  bit         m_valid  = 1'b0;
  bit         m_active = 1'b0;
  bit         m_align  = 1'b0;
  bit         m_parity = 1'b0;
  logic [7:0] m_page   = 8'h00;
  logic [7:0] m_latch  = 8'h00;
  int         m_tick   = 0;

  // Per-transfer observations taken from the DUT outputs.
  int          stall   = 0;
  logic [15:0] rq[$];
  logic [7:0]  wq[$];
  bit          last_rd = 1'b0;

  // Compare, record, then advance the model with this cycle's inputs.
  always @(negedge clock) begin
    logic [15:0] e_a;
    logic [7:0]  e_d;
    logic        e_r, e_w, e_ce, e_busy;
    int          j;
    if (m_valid) begin
      if (!m_active) begin
        e_a = io.cpu_a; e_d = io.cpu_d; e_r = io.cpu_r; e_w = io.cpu_w;
        e_ce = ce; e_busy = 1'b0;
      end else begin
        e_a = OAM; e_d = m_latch; e_r = 1'b0; e_w = 1'b0;
        e_ce = 1'b0; e_busy = 1'b1;
        j = m_tick - 1 - int'(m_align);
        if (m_tick >= 1 + int'(m_align)) begin
          if (j % 2 == 0) begin
            e_a = {m_page, 8'(j / 2)};
            e_r = 1'b1;
          end else begin
            e_w = 1'b1;
          end
        end
      end
      check("cycle", {io.bus_a, io.bus_d, io.bus_r, io.bus_w, io.cpu_ce, io.busy, 4'b0000},
                     {e_a, e_d, e_r, e_w, e_ce, e_busy, 4'b0000});

      if (!reset && ce) begin
        if (!io.cpu_ce) stall++;
        if (io.busy && io.bus_r) begin
          rq.push_back(io.bus_a);
          last_rd = 1'b1;
        end
        if (io.busy && io.bus_w) begin
          check("write_after_read", 32'(last_rd), 32'd1);
          last_rd = 1'b0;
          wq.push_back(io.bus_d);
        end
      end
    end

    if (reset) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_parity = 1'b0;
      m_latch  = 8'h00;
      m_page   = 8'h00;
    end else if (m_valid && ce) begin
      if (!m_active) begin
        if (io.cpu_w && io.cpu_a == 16'h4014) begin
          m_active = 1'b1;
          m_tick   = 0;
          m_page   = io.cpu_d;
          m_align  = 1'b0;
          stall    = 0;
          last_rd  = 1'b0;
          rq.delete();
          wq.delete();
        end
      end else begin
        if (m_tick == 0) begin
          m_align = m_parity;
        end else if (m_tick >= 1 + int'(m_align)) begin
          j = m_tick - 1 - int'(m_align);
          if (j % 2 == 0) m_latch = mem[{m_page, 8'(j / 2)}];
          else if (j == 511) m_active = 1'b0;
        end
        m_tick++;
      end
      m_parity = ~m_parity;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic c, input logic [15:0] a, input logic [7:0] d,
                        input logic r, input logic w);
    ce = c; io.cpu_a = a; io.cpu_d = d; io.cpu_r = r; io.cpu_w = w;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Trigger a transfer with the requested phase at HALT, ticking ce every
  // `period` clocks, optionally stopping after `abort_at` written bytes.
  task automatic run_dma(input logic [7:0] page, input bit want_par, input int period,
                         input int abort_at);
    int budget;
    int cnt;
    // The HALT phase is the inverse of the phase on the triggering tick.
    if (m_parity == want_par) begin
      set_in(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
      step();
    end
    set_in(1'b1, 16'h4014, page, 1'b0, 1'b1);
    step();
    budget = 0;
    cnt = 1;
    while (m_active && budget < 3000 && !(abort_at > 0 && wq.size() >= abort_at)) begin
      // Forced trigger writes during the transfer must be ignored.
      set_in((cnt % period) == 0, 16'h4014, 8'hAA, 1'b1, 1'b1);
      cnt++;
      budget++;
      step();
    end
    if (abort_at == 0) check("dma_done_in_budget", 32'(m_active), 32'd0);
    set_in(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_dma(input logic [7:0] page, input int exp_stall);
    logic [7:0] exp_d;
    check("stall_ticks", 32'(stall), 32'(exp_stall));
    check("read_count", 32'(rq.size()), 32'd256);
    check("write_count", 32'(wq.size()), 32'd256);
    check("busy_after", 32'(io.busy), 32'd0);
    for (int i = 0; i < 256 && i < rq.size(); i++)
      check("read_addr", 32'(rq[i]), 32'({page, 8'(i)}));
    for (int i = 0; i < 256 && i < wq.size(); i++) begin
      exp_d = (page == 8'hFF) ? 8'(255 - i) : 8'(i);
      check("write_data", 32'(wq[i]), 32'(exp_d));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 5 + (i >> 8) * 3 + 1);
    for (int i = 0; i < 256; i++) begin
      mem[16'(16'h0200 + i)] = 8'(i);
      mem[16'(16'hFF00 + i)] = 8'(255 - i);
    end

    // Reset, with a trigger write present that reset must override.
    reset = 1'b1;
    set_in(1'b1, 16'h4014, 8'h07, 1'b0, 1'b1);
    step();
    step();
    reset = 1'b0;

    // Reset state: idle pass-through.
    set_in(1'b1, 16'h1234, 8'h9A, 1'b1, 1'b0);
    #1;
    check("rst_busy", 32'(io.busy), 32'd0);
    check("rst_cpu_ce", 32'(io.cpu_ce), 32'd1);
    check("rst_bus_a", 32'(io.bus_a), 32'h1234);
    check("rst_bus_d", 32'(io.bus_d), 32'h9A);
    check("rst_bus_r", 32'(io.bus_r), 32'd1);
    step();

    // Pass-through: read $8000, then write $55 to $0300 (with and without ce).
    set_in(1'b1, 16'h8000, 8'h00, 1'b1, 1'b0);
    #1;
    check("pt_read_a", 32'(io.bus_a), 32'h8000);
    check("pt_read_rw", 32'({io.bus_r, io.bus_w}), 32'b10);
    step();
    set_in(1'b0, 16'h0300, 8'h55, 1'b0, 1'b1);
    #1;
    check("pt_write_noce", 32'({io.bus_a, io.bus_d, io.bus_w, io.cpu_ce}), 32'({16'h0300, 8'h55, 1'b1, 1'b0}));
    step();
    set_in(1'b1, 16'h0300, 8'h55, 1'b0, 1'b1);
    #1;
    check("pt_write_ce", 32'({io.bus_w, io.cpu_ce, io.busy}), 32'b110);
    step();
    set_in(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
    step();

    // Even phase at HALT: 513 stalled ticks.
    run_dma(8'h02, 1'b0, 1, 0);
    check_dma(8'h02, 513);
    step();

    // Odd phase at HALT: one ALIGN tick, 514 stalled ticks.
    run_dma(8'h02, 1'b1, 1, 0);
    check_dma(8'h02, 514);
    step();

    // ce every third clock.
    run_dma(8'h02, 1'b0, 3, 0);
    check_dma(8'h02, 513);
    step();

    // Page $FF: no wrap out of the page.
    run_dma(8'hFF, 1'b1, 1, 0);
    check_dma(8'hFF, 514);
    step();

    // Reset in the middle of a transfer of page $03.
    run_dma(8'h03, 1'b0, 1, 100);
    check("abort_first_read", 32'(rq[0]), 32'h0300);
    check("abort_bytes", 32'(wq.size()), 32'd100);
    check("abort_busy", 32'(io.busy), 32'd1);
    reset = 1'b1;
    set_in(1'b1, 16'h4014, 8'h05, 1'b0, 1'b1);
    step();
    reset = 1'b0;
    set_in(1'b1, 16'h0300, 8'h11, 1'b1, 1'b0);
    #1;
    check("post_rst_busy", 32'(io.busy), 32'd0);
    check("post_rst_cpu_ce", 32'(io.cpu_ce), 32'd1);
    check("post_rst_bus", 32'({io.bus_a, io.bus_d, io.bus_r, io.bus_w}), 32'({16'h0300, 8'h11, 1'b1, 1'b0}));
    step();

    // Restart after reset begins again at offset 0.
    run_dma(8'h02, 1'b1, 1, 0);
    check_dma(8'h02, 514);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sprite DMA sequencer and bus arbiter between the 6502 core and the system bus.
- A CPU write to $4014 latches a source page, stalls the CPU by gating its chip-enable, and copies 256 bytes from {page,00..FF} to the PPU OAM data port $2004.
- Sits between the CPU core and the memory/PPU decoder. It owns the bus during transfer and passes the CPU through otherwise.

Parameters:
- DMA_REG, 16'h4014, CPU write address that triggers DMA
- OAM_DATA, 16'h2004, destination address for every DMA write
- PARITY_INIT, 1'b0, reset value of the CPU-cycle parity bit

Ports:
- clock  in  1  system clock (25 MHz)
- reset  in  1  synchronous, active-high reset
- ce  in  1  CPU cycle tick; all state advances only when ce=1
- cpu_ce  out  1  gated tick to CPU core
- cpu_a  in  16  CPU address
- cpu_d  in  8  CPU write data
- cpu_r  in  1  CPU read strobe
- cpu_w  in  1  CPU write strobe
- bus_a  out  16  address to memory/PPU decoder
- bus_d  out  8  write data to bus
- bus_r  out  1  read strobe to bus
- bus_w  out  1  write strobe to bus
- bus_i  in  8  read data from bus, valid combinationally for current bus_a
- busy  out  1  DMA in progress (state != IDLE)

Behaviour:
- Reset values: state=IDLE, page=0, idx=0, data latch=0, parity=PARITY_INIT, busy=0. Outputs pass the CPU through: bus_a=cpu_a, bus_d=cpu_d, bus_r=cpu_r, bus_w=cpu_w, cpu_ce=ce.
- Parity toggles on every ce tick, including during DMA. It is never cleared except by reset.
- States: IDLE, HALT, ALIGN, READ, WRITE. The state register is updated only on clock edges with ce=1.
- IDLE:
  - Pass-through mux active; cpu_ce=ce.
  - On a ce tick with cpu_w=1 and cpu_a==DMA_REG: page<=cpu_d, idx<=0, state<=HALT. That write still reaches the bus on this tick.
- In any non-IDLE state: cpu_ce=0 and bus_r=bus_w=0, unless the state drives them below. bus_a/bus_d come from DMA; CPU inputs are ignored.
- HALT: one tick, no bus access (bus_a=OAM_DATA, strobes 0). Next state is ALIGN if parity==1 on this tick, else READ.
- ALIGN: one tick, no bus access, then READ.
- READ: bus_a={page,idx}, bus_r=1. On the ce edge, latch<=bus_i and state<=WRITE.
- WRITE: bus_a=OAM_DATA, bus_d=latch, bus_w=1. On the ce edge:
  - if idx==8'hFF, state<=IDLE and idx<=0;
  - else idx<=idx+1 (8-bit) and state<=READ.
- Total stall: 513 ce ticks (parity 0 at HALT) or 514 ticks (parity 1). cpu_ce resumes on the first tick after the final WRITE.
- ce=0 cycles: no state change, outputs held, cpu_ce=0.
- Boundary conditions:
  - page=$FF reads $FF00..$FFFF with no wrap into other pages.
  - A write to DMA_REG while busy cannot occur, because the CPU is stalled; if forced on cpu_* it is ignored.
  - A $4014 write on the same tick the DMA finishes (WRITE→IDLE) is ignored.
  - reset asserted mid-transfer returns to IDLE on that edge, with pass-through and cpu_ce=ce immediately after.
- All outputs are a combinational function of state, idx, page, latch and the CPU inputs. There is no extra pipeline latency on pass-through.

Test Plan:
- Pass-through: no DMA, CPU reads $8000 then writes $55 to $0300 → bus_* mirror cpu_* each cycle, cpu_ce==ce, busy=0.
- Even-parity DMA: memory $0200+i = i, write $02 to $4014 with parity=0 at HALT → 513 stalled ticks. 256 writes to $2004 carry data 00..FF in order, each preceded by a read of $02ii. busy falls after the last write.
- Odd-parity DMA: same as above but parity=1 at HALT → exactly one ALIGN tick, 514 stalled ticks, identical data sequence.
- ce gating: ce asserted every 3rd clock during DMA → same byte sequence and tick counts; outputs stable between ticks.
- Page $FF: write $FF to $4014 → reads $FF00..$FFFF, final idx wraps to 0, return to IDLE.
- Reset mid-transfer: assert reset after 100 bytes → next cycle IDLE, busy=0, cpu_ce=ce. A new $4014 write restarts at idx=0.
